signed_mac_sequencer: RTL and testbench

- Upstream/downstream companion to the sequential shift-add signed multiplier (St/Done handshake, 16x16 operands, 32-bit Product).
- Accepts operand pairs over a valid/ready interface and drives the multiplier's St, Mtp and Mtc.
- Captures each Product, sign-extends it and accumulates NUM_TERMS products into one signed sum.
- Presents the sum on a valid/ready output port and clears itself for the next frame.

---
 rtl/signed_mac_sequencer.sv | 140 ++++++++++++++
 tb/tb_signed_mac_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_mac_sequencer.sv
// signed_mac_sequencer
// Feeds operand pairs to a sequential St/Done signed multiplier, accumulates
// NUM_TERMS sign-extended products into one signed frame sum and presents the
// sum on a valid/ready port. The frame is cleared once the sum is consumed.
// Optional build macro: MAC_SAT_EN. When it is defined, signed overflow clamps
// the accumulator to the most positive/negative value. When it is undefined,
// the sum wraps. ovf is set on overflow in both builds.
//
// state | meaning
// ------+-------------------------------------------------------------
// SYNC  | wait for Done=0, because the multiplier has no reset
// IDLE  | in_ready=1, accept one operand pair
// RUN   | St=1, operands held, capture Product on the first Done=1
// DROP  | St=0, wait for Done to fall, then decide whether the frame is complete
// OUT   | acc_valid=1, hold the sum until acc_ready
module signed_mac_sequencer #(
   parameter int MP_W      = 16,
   parameter int MC_W      = 16,
   parameter int PROD_W    = 32,
   parameter int ACC_W     = 40,
   parameter int NUM_TERMS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MP_W-1:0]   in_mtp,
   input  logic [MC_W-1:0]   in_mtc,
   output logic              St,
   output logic [MP_W-1:0]   Mtp,
   output logic [MC_W-1:0]   Mtc,
   input  logic              Done,
   input  logic [PROD_W-1:0] Product,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf
);

   localparam logic [2:0] S_SYNC = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_DROP = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   localparam int CNT_W = $clog2(NUM_TERMS + 1);
   localparam logic [CNT_W-1:0] TERMS = CNT_W'(NUM_TERMS);

   logic [2:0]              state;
   logic [CNT_W-1:0]        term_cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] acc_next;
   logic                    add_ovf;

   assign acc_out = acc;

   // Sign-extend the product, add it, and detect signed overflow of the addition.
   always_comb begin
      prod_ext = ACC_W'($signed(Product));
      sum      = acc + prod_ext;
      add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
      acc_next = sum;
`ifdef MAC_SAT_EN
      if (add_ovf)
         acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
`endif
   end

   // Sequencing FSM. Every output is a register updated on the state transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_SYNC;
         in_ready  <= 1'b0;
         St        <= 1'b0;
         Mtp       <= '0;
         Mtc       <= '0;
         acc_valid <= 1'b0;
         acc       <= '0;
         ovf       <= 1'b0;
         term_cnt  <= '0;
      end else begin
         case (state)
            S_SYNC: begin
               if (!Done) begin
                  in_ready <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  Mtp      <= in_mtp;
                  Mtc      <= in_mtc;
                  in_ready <= 1'b0;
                  St       <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (Done) begin
                  acc      <= acc_next;
                  ovf      <= ovf | add_ovf;
                  term_cnt <= term_cnt + CNT_W'(1);
                  St       <= 1'b0;
                  state    <= S_DROP;
               end
            end
            S_DROP: begin
               if (!Done) begin
                  if (term_cnt == TERMS) begin
                     acc_valid <= 1'b1;
                     state     <= S_OUT;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= S_IDLE;
                  end
               end
            end
            S_OUT: begin
               if (acc_valid && acc_ready) begin
                  acc       <= '0;
                  ovf       <= 1'b0;
                  term_cnt  <= '0;
                  acc_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               in_ready <= 1'b0;
               St       <= 1'b0;
               state    <= S_SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_mac_sequencer.sv
// Bench for signed_mac_sequencer. It instantiates two DUTs in lockstep, one
// with ACC_W=40 and one with ACC_W=33, and drives both from a behavioural
// St/Done multiplier model. Expected frame sums are pushed to a scoreboard
// when a frame is driven and popped when acc_valid appears.
module tb_signed_mac_sequencer;

   localparam int LAT = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_mtp = '0;
   logic [15:0] in_mtc = '0;
   logic        acc_ready = 1'b0;
   logic        force_done = 1'b0;

   logic        in_ready1, St1, acc_valid1, ovf1;
   logic [15:0] Mtp1, Mtc1;
   logic [39:0] acc_out1;
   logic        in_ready2, St2, acc_valid2, ovf2;
   logic [15:0] Mtp2, Mtc2;
   logic [32:0] acc_out2;

   logic               m_busy = 1'b0;
   logic               m_done = 1'b0;
   int                 m_cnt  = 0;
   logic signed [31:0] m_prod = '0;
   logic               Done;
   logic [31:0]        Product;

   int errors = 0;
   int checks = 0;

   typedef struct {
      longint s40;
      bit     o40;
      longint s33;
      bit     o33;
   } exp_t;
   exp_t sb[$];

   assign Done    = m_done | force_done;
   assign Product = m_prod;

   always #5 clk = ~clk;

   signed_mac_sequencer #(.MP_W(16), .MC_W(16), .PROD_W(32), .ACC_W(40), .NUM_TERMS(4)) dut40 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_mtp(in_mtp), .in_mtc(in_mtc), .St(St1), .Mtp(Mtp1), .Mtc(Mtc1),
      .Done(Done), .Product(Product), .acc_valid(acc_valid1), .acc_ready(acc_ready),
      .acc_out(acc_out1), .ovf(ovf1)
   );

   signed_mac_sequencer #(.MP_W(16), .MC_W(16), .PROD_W(32), .ACC_W(33), .NUM_TERMS(4)) dut33 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_mtp(in_mtp), .in_mtc(in_mtc), .St(St2), .Mtp(Mtp2), .Mtc(Mtc2),
      .Done(Done), .Product(Product), .acc_valid(acc_valid2), .acc_ready(acc_ready),
      .acc_out(acc_out2), .ovf(ovf2)
   );

   // Behavioural multiplier: LAT cycles after St, raise Done with the product and hold it until St falls.
   always @(posedge clk) begin
      if (!m_busy && !m_done && St1) begin
         m_busy <= 1'b1;
         m_cnt  <= LAT;
      end else if (m_busy) begin
         if (m_cnt == 0) begin
            m_done <= 1'b1;
            m_prod <= 32'($signed(Mtp1)) * 32'($signed(Mtc1));
            m_busy <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (m_done && !St1) begin
         m_done <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference accumulate at width w, computed with exact integer arithmetic.
   function automatic void add_term(input int w, input longint p, inout longint acc, inout bit o);
      longint mx, mn, s;
      mx = (64'sd1 <<< (w - 1)) - 1;
      mn = -(64'sd1 <<< (w - 1));
      s  = acc + p;
      if (s > mx || s < mn) begin
         o = 1'b1;
`ifdef MAC_SAT_EN
         s = (s > mx) ? mx : mn;
`else
         s = (s > mx) ? s - (64'sd1 <<< w) : s + (64'sd1 <<< w);
`endif
      end
      acc = s;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!in_ready1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready1, 1);
   endtask

   task automatic send_pair(input int a, input int b, input bit junk);
      wait_ready();
      in_mtp   = a[15:0];
      in_mtc   = b[15:0];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("st_after_accept", St1, 1);
      check("mtp_held", $signed(Mtp1), a);
      check("mtc_held", $signed(Mtc1), b);
      check("ready_low_run", in_ready1, 0);
      if (junk) begin
         in_mtp   = ~a[15:0];
         in_mtc   = 16'h1234;
         in_valid = 1'b1;
         repeat (LAT + 2) @(negedge clk);
         check("junk_not_taken_ready", in_ready1, 0);
         check("junk_mtp_stable", $signed(Mtp1), a);
         in_valid = 1'b0;
      end
   endtask

   task automatic run_frame(input int a[4], input int b[4], input bit junk);
      exp_t e;
      e.s40 = 0; e.o40 = 1'b0; e.s33 = 0; e.o33 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         add_term(40, longint'(a[i]) * longint'(b[i]), e.s40, e.o40);
         add_term(33, longint'(a[i]) * longint'(b[i]), e.s33, e.o33);
      end
      sb.push_back(e);
      for (int i = 0; i < 4; i++) send_pair(a[i], b[i], junk);
   endtask

   task automatic collect(input int hold);
      int   n = 0;
      exp_t e;
      while (!acc_valid1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("acc_valid_wait", acc_valid1, 1);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      check("acc_out40", $signed(acc_out1), e.s40);
      check("ovf40", ovf1, e.o40);
      check("acc_valid33", acc_valid2, 1);
      check("acc_out33", $signed(acc_out2), e.s33);
      check("ovf33", ovf2, e.o33);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_acc_out", $signed(acc_out1), e.s40);
         check("hold_valid", acc_valid1, 1);
         check("hold_ready_low", in_ready1, 0);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      check("valid_clear", acc_valid1, 0);
      check("acc_clear40", acc_out1, 0);
      check("acc_clear33", acc_out2, 0);
      check("ovf_clear", ovf2, 0);
      check("ready_after_out", in_ready1, 1);
   endtask

   initial begin
      // Reset state, with the multiplier stuck in its done state.
      rst        = 1'b1;
      force_done = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready1, 0);
      check("rst_St", St1, 0);
      check("rst_Mtp", Mtp1, 0);
      check("rst_Mtc", Mtc1, 0);
      check("rst_acc_valid", acc_valid1, 0);
      check("rst_acc_out", acc_out1, 0);
      check("rst_ovf", ovf1, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("sync_wait_done_low", in_ready1, 0);
      force_done = 1'b0;
      wait_ready();

      run_frame('{3, -2, 100, -1}, '{5, 7, -100, -1}, 1'b0);
      collect(0);

      run_frame('{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, 1'b0);
      collect(10);

      run_frame('{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0);
      collect(0);

      // Done pulse while idle must not be captured.
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      @(negedge clk);
      check("done_in_idle_ignored", in_ready1, 1);

      run_frame('{7, -32768, 1234, -5}, '{-3, 32767, -567, -5}, 1'b1);
      collect(0);

      // Asynchronous reset in the middle of a multiply.
      send_pair(9, 9, 1'b0);
      collect_skip_pair();
      send_pair(-4, 6, 1'b0);
      @(negedge clk);
      check("pre_rst_St", St1, 1);
      #2 rst = 1'b1;
      #1;
      check("async_St", St1, 0);
      check("async_in_ready", in_ready1, 0);
      check("async_St33", St2, 0);
      force_done = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("post_rst_sync_hold", in_ready1, 0);
      force_done = 1'b0;
      wait_ready();

      run_frame('{-7, 11, 0, 32767}, '{9, 13, -1, 32767}, 1'b0);
      collect(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // After one accepted pair, wait until the sequencer is ready for the next one.
   task automatic collect_skip_pair();
      wait_ready();
   endtask

endmodule
